// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory fetch FSM,
// branch redirect handling and the IF/ID pipeline register feeding decode.
module if_stage_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_EN_IF,
   input  logic        reg_FD_EN,
   input  logic        reg_FD_stall,
   input  logic        reg_FD_flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_IF,
   output logic [31:0] PC_ID,
   output logic [31:0] inst_ID,
   output logic        valid_ID,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DROP
   } state_t;

   state_t      stateQ, stateD;
   logic [31:0] pcQ, pcD;
   logic [31:0] bufQ, bufD;
   logic [31:0] dropAddrQ, dropAddrD;
   logic [31:0] pcIdQ, pcIdD;
   logic [31:0] instIdQ, instIdD;
   logic        validIdQ, validIdD;

   logic        issueOk;
   logic        fdHold;
   logic        issue;
   logic [31:0] issueInst;
   logic [31:0] redirectPc;

   assign issueOk    = PC_EN_IF & reg_FD_EN & ~reg_FD_stall;
   assign fdHold     = ~reg_FD_EN | reg_FD_stall;
   assign redirectPc = branch_target & ~32'h0000_0003;

   // Fetch FSM next state; a branch always wins over issuing, so wrong-path
   // data (ack in the redirect cycle, buffered data, or a DROP ack) is discarded.
   always_comb begin
      stateD    = stateQ;
      pcD       = pcQ;
      bufD      = bufQ;
      dropAddrD = dropAddrQ;
      issue     = 1'b0;
      issueInst = imem_rdata;
      case (stateQ)
         IDLE: stateD = FETCH;
         FETCH: begin
            if (branch_taken) begin
               pcD = redirectPc;
               if (!imem_ack) begin
                  stateD    = DROP;
                  dropAddrD = pcQ;
               end
            end else if (imem_ack) begin
               if (issueOk) begin
                  issue = 1'b1;
                  pcD   = pcQ + 32'd4;
               end else begin
                  bufD   = imem_rdata;
                  stateD = HOLD;
               end
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pcD    = redirectPc;
               stateD = FETCH;
            end else if (issueOk) begin
               issue     = 1'b1;
               issueInst = bufQ;
               pcD       = pcQ + 32'd4;
               stateD    = FETCH;
            end
         end
         DROP: begin
            if (branch_taken) pcD = redirectPc;
            if (imem_ack) stateD = FETCH;
         end
         default: stateD = IDLE;
      endcase
   end

   // IF/ID register: flush beats hold, hold beats a new instruction, and an
   // empty cycle inserts a bubble. PC_ID is left alone on bubbles.
   always_comb begin
      pcIdD    = pcIdQ;
      instIdD  = instIdQ;
      validIdD = validIdQ;
      if (reg_FD_flush) begin
         instIdD  = NOP_INST;
         validIdD = 1'b0;
      end else if (!fdHold) begin
         if (issue) begin
            pcIdD    = pcQ;
            instIdD  = issueInst;
            validIdD = 1'b1;
         end else begin
            instIdD  = NOP_INST;
            validIdD = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         pcQ       <= RESET_PC;
         bufQ      <= 32'h0;
         dropAddrQ <= 32'h0;
         pcIdQ     <= 32'h0;
         instIdQ   <= NOP_INST;
         validIdQ  <= 1'b0;
      end else begin
         stateQ    <= stateD;
         pcQ       <= pcD;
         bufQ      <= bufD;
         dropAddrQ <= dropAddrD;
         pcIdQ     <= pcIdD;
         instIdQ   <= instIdD;
         validIdQ  <= validIdD;
      end
   end

   // While dropping, the memory still sees the abandoned address until it acks.
   assign imem_req   = (stateQ == FETCH) || (stateQ == DROP);
   assign imem_addr  = (stateQ == DROP) ? dropAddrQ : pcQ;
   assign fetch_busy = ((stateQ == FETCH) && !imem_ack) || (stateQ == DROP);
   assign PC_IF      = pcQ;
   assign PC_ID      = pcIdQ;
   assign inst_ID    = instIdQ;
   assign valid_ID   = validIdQ;

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed testbench for if_stage_fetch_unit: sequential fetch, stall/hold,
// branch during an outstanding fetch, flush, PC wrap and asynchronous reset.
module tb_if_stage_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        PC_EN_IF;
   logic        reg_FD_EN;
   logic        reg_FD_stall;
   logic        reg_FD_flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] PC_IF;
   logic [31:0] PC_ID;
   logic [31:0] inst_ID;
   logic        valid_ID;
   logic        fetch_busy;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_stage_fetch_unit dut (
      .clk(clk),
      .rst_n(rst_n),
      .PC_EN_IF(PC_EN_IF),
      .reg_FD_EN(reg_FD_EN),
      .reg_FD_stall(reg_FD_stall),
      .reg_FD_flush(reg_FD_flush),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .PC_IF(PC_IF),
      .PC_ID(PC_ID),
      .inst_ID(inst_ID),
      .valid_ID(valid_ID),
      .fetch_busy(fetch_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; PC_EN_IF = 1'b1; reg_FD_EN = 1'b1; reg_FD_stall = 1'b0;
      reg_FD_flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      tick();
      checks++;
      if (PC_IF !== 32'h0 || imem_req !== 1'b0 || PC_ID !== 32'h0 || inst_ID !== NOP || valid_ID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got pc=%h req=%b pcid=%h inst=%h valid=%b, expected pc=0 req=0 pcid=0 inst=%h valid=0",
                  PC_IF, imem_req, PC_ID, inst_ID, valid_ID, NOP);
      end
   endtask

   task automatic test_sequential_fetch();
      rst_n = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h00500093;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_ID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_to_fetch: got req=%b addr=%h valid=%b, expected req=1 addr=0 valid=0", imem_req, imem_addr, valid_ID);
      end
      tick();
      checks++;
      if (PC_ID !== 32'h0 || inst_ID !== 32'h00500093 || valid_ID !== 1'b1 || imem_addr !== 32'h4) begin
         errors++;
         $display("[TB] FAIL first_issue: got pcid=%h inst=%h valid=%b addr=%h, expected 0/00500093/1/4", PC_ID, inst_ID, valid_ID, imem_addr);
      end
      imem_rdata = 32'h00100113;
      tick();
      checks++;
      if (PC_ID !== 32'h4 || inst_ID !== 32'h00100113 || valid_ID !== 1'b1 || imem_addr !== 32'h8 || PC_IF !== 32'h8) begin
         errors++;
         $display("[TB] FAIL back_to_back: got pcid=%h inst=%h valid=%b addr=%h pc=%h, expected 4/00100113/1/8/8", PC_ID, inst_ID, valid_ID, imem_addr, PC_IF);
      end
   endtask

   task automatic test_stall_hold();
      reg_FD_stall = 1'b1; PC_EN_IF = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h00200193;
      tick();
      checks++;
      if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || PC_ID !== 32'h4 || inst_ID !== 32'h00100113 || valid_ID !== 1'b1 || PC_IF !== 32'h8) begin
         errors++;
         $display("[TB] FAIL hold_entry: got req=%b busy=%b pcid=%h inst=%h valid=%b pc=%h, expected 0/0/4/00100113/1/8",
                  imem_req, fetch_busy, PC_ID, inst_ID, valid_ID, PC_IF);
      end
      imem_ack = 1'b0; imem_rdata = 32'hBAD0BAD0;
      tick();
      checks++;
      if (imem_req !== 1'b0 || PC_ID !== 32'h4 || inst_ID !== 32'h00100113 || valid_ID !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_frozen: got req=%b pcid=%h inst=%h valid=%b, expected 0/4/00100113/1", imem_req, PC_ID, inst_ID, valid_ID);
      end
      reg_FD_stall = 1'b0; PC_EN_IF = 1'b1;
      tick();
      checks++;
      if (PC_ID !== 32'h8 || inst_ID !== 32'h00200193 || valid_ID !== 1'b1 || PC_IF !== 32'hC || imem_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_release: got pcid=%h inst=%h valid=%b pc=%h req=%b, expected 8/00200193/1/c/1", PC_ID, inst_ID, valid_ID, PC_IF, imem_req);
      end
   endtask

   task automatic test_branch_drop();
      imem_ack = 1'b1; imem_rdata = 32'h00300213;
      tick();
      checks++;
      if (PC_ID !== 32'hC || inst_ID !== 32'h00300213 || PC_IF !== 32'h10) begin
         errors++;
         $display("[TB] FAIL fetch_at_c: got pcid=%h inst=%h pc=%h, expected c/00300213/10", PC_ID, inst_ID, PC_IF);
      end
      imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
      #1;
      checks++;
      if (fetch_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_waiting: got %b expected 1", fetch_busy);
      end
      tick();
      branch_taken = 1'b0;
      checks++;
      if (PC_IF !== 32'h40 || imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_busy !== 1'b1 || valid_ID !== 1'b0 || inst_ID !== NOP) begin
         errors++;
         $display("[TB] FAIL drop_entry: got pc=%h req=%b addr=%h busy=%b valid=%b inst=%h, expected 40/1/10/1/0/%h",
                  PC_IF, imem_req, imem_addr, fetch_busy, valid_ID, inst_ID, NOP);
      end
      tick();
      checks++;
      if (imem_addr !== 32'h10 || fetch_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drop_wait: got addr=%h busy=%b, expected 10/1", imem_addr, fetch_busy);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();
      imem_ack = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'h40 || imem_req !== 1'b1 || valid_ID !== 1'b0 || inst_ID !== NOP || fetch_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drop_exit: got addr=%h req=%b valid=%b inst=%h busy=%b, expected 40/1/0/%h/1", imem_addr, imem_req, valid_ID, inst_ID, NOP, fetch_busy);
      end
   endtask

   task automatic test_flush();
      imem_ack = 1'b1; imem_rdata = 32'h00400293;
      tick();
      checks++;
      if (PC_ID !== 32'h40 || inst_ID !== 32'h00400293 || valid_ID !== 1'b1 || PC_IF !== 32'h44) begin
         errors++;
         $display("[TB] FAIL fetch_at_40: got pcid=%h inst=%h valid=%b pc=%h, expected 40/00400293/1/44", PC_ID, inst_ID, valid_ID, PC_IF);
      end
      imem_ack = 1'b0; PC_EN_IF = 1'b0; reg_FD_EN = 1'b0;
      tick();
      checks++;
      if (inst_ID !== 32'h00400293 || valid_ID !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fd_disabled_hold: got inst=%h valid=%b, expected 00400293/1", inst_ID, valid_ID);
      end
      reg_FD_flush = 1'b1;
      tick();
      checks++;
      if (inst_ID !== NOP || valid_ID !== 1'b0 || PC_IF !== 32'h44) begin
         errors++;
         $display("[TB] FAIL flush: got inst=%h valid=%b pc=%h, expected %h/0/44", inst_ID, valid_ID, PC_IF, NOP);
      end
      reg_FD_flush = 1'b0; reg_FD_EN = 1'b1; PC_EN_IF = 1'b1;
   endtask

   task automatic test_pc_wrap();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();
      branch_taken = 1'b0;
      checks++;
      if (PC_IF !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1 || valid_ID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL branch_with_ack: got pc=%h addr=%h req=%b valid=%b, expected fffffffc/fffffffc/1/0", PC_IF, imem_addr, imem_req, valid_ID);
      end
      imem_rdata = 32'h00500313;
      tick();
      checks++;
      if (PC_IF !== 32'h0 || PC_ID !== 32'hFFFF_FFFC || inst_ID !== 32'h00500313 || valid_ID !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pc_wrap: got pc=%h pcid=%h inst=%h valid=%b, expected 0/fffffffc/00500313/1", PC_IF, PC_ID, inst_ID, valid_ID);
      end
   endtask

   task automatic test_async_reset();
      imem_rdata = 32'h00600393;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (PC_IF !== 32'h4 || valid_ID !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_fetch: got pc=%h valid=%b, expected 4/1", PC_IF, valid_ID);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (PC_IF !== 32'h0 || imem_req !== 1'b0 || PC_ID !== 32'h0 || inst_ID !== NOP || valid_ID !== 1'b0 || fetch_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got pc=%h req=%b pcid=%h inst=%h valid=%b busy=%b, expected 0/0/0/%h/0/0",
                  PC_IF, imem_req, PC_ID, inst_ID, valid_ID, fetch_busy, NOP);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || PC_IF !== 32'h0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got req=%b pc=%h, expected 0/0", imem_req, PC_IF);
      end
      tick();
      imem_ack = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_ID !== 1'b0 || PC_IF !== 32'h0 || inst_ID !== NOP) begin
         errors++;
         $display("[TB] FAIL late_ack_ignored: got req=%b addr=%h valid=%b pc=%h inst=%h, expected 1/0/0/0/%h", imem_req, imem_addr, valid_ID, PC_IF, inst_ID, NOP);
      end
   endtask

   initial begin
      test_reset();
      test_sequential_fetch();
      test_stall_hold();
      test_branch_drop();
      test_flush();
      test_pc_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
